data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
- Responder end of the data-memory request interface that the memory stage drives.
- Accepts one word read or write request per cycle over a valid/ready handshake.
- Services reads with a fixed pipelined latency and holds read responses in a bounded queue, so the requester may stall without losing data.
- Sits between the memory pipeline stage and the data memory array; it owns the array.

Parameters:
ADDR_WIDTH, 10, number of word-index bits; the array holds 2^ADDR_WIDTH 32-bit words
READ_LATENCY, 2, cycles from read accept to data entering the response queue; minimum 1
QUEUE_DEPTH, 4, maximum outstanding reads (in flight plus queued); power of two, minimum 2

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
reqValid  in  1  request present
reqReady  out  1  responder can accept a request this cycle
reqWrite  in  1  1 = write, 0 = read
reqAddress  in  32  byte address; word index = reqAddress[ADDR_WIDTH+1:2]
reqWriteData  in  32  write data
reqByteEnable  in  4  per-byte write enable; bit i covers bits 8i+7:8i
reqProgramCounter  in  32  PC of the issuing instruction; carried with reads, returned on the response
respValid  out  1  response at queue head is valid
respReady  in  1  requester consumes the head response
respData  out  32  read data
respMisaligned  out  1  head response came from a misaligned read
respProgramCounter  out  32  PC carried with the head response
outstanding  out  $clog2(QUEUE_DEPTH)+1  reads in flight plus queued

Behaviour:
- Accept: a request is accepted on a rising edge where reqValid && reqReady.
- reqReady:
  - 0 while reset is low.
  - Otherwise 1 iff outstanding < QUEUE_DEPTH.
  - Applies to both reads and writes, so request order is preserved.
- Write:
  - Performed at the accept edge; enabled bytes are updated.
  - No response is generated and no credit is consumed.
- Read:
  - Array is sampled at the accept edge.
  - Data, misaligned flag and PC shift through a READ_LATENCY-deep valid-tagged pipeline, then push into the FIFO response queue.
  - A read accepted at edge N, with an empty queue, gives respValid=1 during the cycle after edge N+READ_LATENCY-1 (registered output); respData is valid in that same cycle.
- Read-after-write: a read accepted at any edge after a write to the same word returns the written data. At most one request is accepted per cycle, so there is no same-edge conflict.
- Queue: respValid = queue not empty. A pop occurs on respValid && respReady.
- outstanding counter:
  - +1 on read accept, -1 on pop.
  - Simultaneous accept and pop leaves it unchanged.
  - Never exceeds QUEUE_DEPTH, so the queue cannot overflow.
- Full: with outstanding == QUEUE_DEPTH, reqReady=0. A pop in that cycle raises reqReady in the next cycle only; there is no combinational ready path from respReady.
- Empty: respValid=0, and respData, respProgramCounter and respMisaligned hold 0.
- Misaligned (reqAddress[1:0] != 0):
  - Write: array is unchanged.
  - Read: responds with respData=0 and respMisaligned=1.
- Out-of-range address: bits above ADDR_WIDTH+1 are ignored, so the address wraps modulo array size.
- Reset (reset low at an edge):
  - Pipeline valids cleared, queue emptied, outstanding=0.
  - respValid=0, respData=0, respMisaligned=0, respProgramCounter=0.
  - In-flight reads are discarded, including during a mid-operation reset.
  - Array contents are preserved.
  - Requests presented during reset are ignored.
- Unknowns: the block asserts, via simulation assertion, that reqValid is never X after reset deassertion, and that a pop never occurs on an empty queue.

Optional Feature:
- Macro: DATA_MEMORY_BYTE_ENABLE_EN.
- Defined: reqByteEnable gates each byte of a write; reqByteEnable=0 gives a write with no effect.
- Undefined: reqByteEnable is ignored and every aligned write updates all 4 bytes.
- Reads are identical in both builds.

Test Plan:
- Reset low 2 cycles, then high → reqReady=1, respValid=0, outstanding=0; array holds pre-loaded value 0xDEADBEEF at word 3.
- Write 0x12345678 to 0x0C, next cycle read 0x0C with PC 0x40, respReady=1, READ_LATENCY=2 → respValid in the 2nd cycle after the read accept edge; respData=0x12345678, respProgramCounter=0x40, respMisaligned=0.
- respReady=0, issue 5 back-to-back reads (QUEUE_DEPTH=4) → 4 accepted, reqReady=0 at outstanding=4. Raise respReady → responses in issue order; reqReady returns 1 the cycle after the first pop.
- Read 0x0D → respData=0, respMisaligned=1. Write 0xFFFFFFFF to 0x0E → word 3 unchanged.
- With DATA_MEMORY_BYTE_ENABLE_EN, write 0xAABBCCDD byteEnable=0b0101 over 0x11223344 → readback 0x11BB33DD. Without the macro → readback 0xAABBCCDD.
- Issue 3 reads, assert reset low for 1 cycle mid-flight → no respValid afterwards, outstanding=0; array data intact on a subsequent read.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: responder side of the data-memory request interface.
// It owns a 2^ADDR_WIDTH x 32-bit word array, performs writes at the accept
// edge, and returns reads through a fixed-latency pipeline into a response
// queue that is bounded by an outstanding-read credit counter.
// Optional build macro: DATA_MEMORY_BYTE_ENABLE_EN (byte-lane write gating).
module data_memory_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic                           reqWrite,
  input  logic [31:0]                    reqAddress,
  input  logic [31:0]                    reqWriteData,
  input  logic [3:0]                     reqByteEnable,
  input  logic [31:0]                    reqProgramCounter,
  output logic                           respValid,
  input  logic                           respReady,
  output logic [31:0]                    respData,
  output logic                           respMisaligned,
  output logic [31:0]                    respProgramCounter,
  output logic [$clog2(QUEUE_DEPTH):0]   outstanding
);

  localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH);
  localparam int CNT_WIDTH   = PTR_WIDTH + 1;
  localparam int WORDS       = 1 << ADDR_WIDTH;
  localparam int ENTRY_WIDTH = 65;  // {misaligned, programCounter[31:0], data[31:0]}

  // Handshakes: a request transfers on a rising edge with reqValid && reqReady;
  // a response transfers on a rising edge with respValid && respReady. Neither
  // ready depends combinationally on the other side's valid or ready.

  logic [31:0]            memArray [WORDS];
  logic                   accept;
  logic                   readAccept;
  logic                   writeAccept;
  logic                   misaligned;
  logic [ADDR_WIDTH-1:0]  wordIndex;
  logic [3:0]             writeMask;
  logic [ENTRY_WIDTH-1:0] readEntry;
  logic                   pushValid;
  logic [ENTRY_WIDTH-1:0] pushEntry;
  logic                   pop;
  logic [ENTRY_WIDTH-1:0] queueMem [QUEUE_DEPTH];
  logic [ENTRY_WIDTH-1:0] headEntry;
  logic [PTR_WIDTH-1:0]   writePtr;
  logic [PTR_WIDTH-1:0]   readPtr;
  logic [CNT_WIDTH-1:0]   queueCount;
  logic                   unusedInputs;

  // Credits cover in-flight plus queued reads, so the queue can never overflow.
  // Writes are throttled too so request order is never reshuffled.
  assign reqReady    = reset && (outstanding < CNT_WIDTH'(QUEUE_DEPTH));
  assign accept      = reqValid && reqReady;
  assign misaligned  = reqAddress[1:0] != 2'b00;
  assign wordIndex   = reqAddress[ADDR_WIDTH+1:2];
  assign readAccept  = accept && !reqWrite;
  assign writeAccept = accept && reqWrite && !misaligned;
  assign readEntry   = {misaligned, reqProgramCounter,
                        misaligned ? 32'h0 : memArray[wordIndex]};

`ifdef DATA_MEMORY_BYTE_ENABLE_EN
  assign writeMask    = reqByteEnable;
  assign unusedInputs = ^reqAddress[31:ADDR_WIDTH+2];
`else
  assign writeMask    = 4'hF;
  assign unusedInputs = ^{reqAddress[31:ADDR_WIDTH+2], reqByteEnable};
`endif

  // Aligned writes update the enabled byte lanes at the accept edge; the array is never reset.
  always_ff @(posedge clock) begin
    if (writeAccept) begin
      for (int b = 0; b < 4; b++) begin
        if (writeMask[b]) memArray[wordIndex][8*b +: 8] <= reqWriteData[8*b +: 8];
      end
    end
  end

  // Read data sampled at the accept edge travels READ_LATENCY-1 register stages;
  // the queue write is the final stage, so latency 1 pushes straight from the array.
  generate
    if (READ_LATENCY == 1) begin : gNoPipe
      assign pushValid = readAccept;
      assign pushEntry = readEntry;
    end else begin : gPipe
      localparam int STAGES = READ_LATENCY - 1;
      logic [STAGES-1:0]             validChain;
      logic [STAGES*ENTRY_WIDTH-1:0] entryChain;

      // Shift the valid-tagged read entries one stage per clock; reset drops in-flight reads.
      always_ff @(posedge clock) begin
        if (!reset) begin
          validChain <= '0;
          entryChain <= '0;
        end else begin
          validChain <= STAGES'({validChain, readAccept});
          entryChain <= (STAGES*ENTRY_WIDTH)'({entryChain, readEntry});
        end
      end

      assign pushValid = validChain[STAGES-1];
      assign pushEntry = entryChain[STAGES*ENTRY_WIDTH-1 -: ENTRY_WIDTH];
    end
  endgenerate

  assign pop = respValid && respReady;

  // Queue storage has no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (pushValid) queueMem[writePtr] <= pushEntry;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      writePtr   <= '0;
      readPtr    <= '0;
      queueCount <= '0;
    end else begin
      if (pushValid) writePtr <= writePtr + 1'b1;
      if (pop)       readPtr  <= readPtr + 1'b1;
      case ({pushValid, pop})
        2'b10:   queueCount <= queueCount + 1'b1;
        2'b01:   queueCount <= queueCount - 1'b1;
        default: queueCount <= queueCount;
      endcase
    end
  end

  // Outstanding credits: taken by a read accept, returned by a response pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({readAccept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign headEntry          = queueMem[readPtr];
  assign respValid          = queueCount != '0;
  assign respData           = respValid ? headEntry[31:0]  : 32'h0;
  assign respProgramCounter = respValid ? headEntry[63:32] : 32'h0;
  assign respMisaligned     = respValid ? headEntry[64]    : 1'b0;

`ifndef SYNTHESIS
  // Out of reset, the request strobe must be defined and pops must never underflow the queue.
  always @(posedge clock) begin
    if (reset) begin
      assert (!$isunknown(reqValid)) else $error("reqValid is unknown after reset");
      assert (!(pop && queueCount == '0)) else $error("response pop on empty queue");
    end
  end
`endif

endmodule
